// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for a five-stage MIPS pipeline: load-use and HI/LO hazards,
// taken-branch flushes, HI/LO busy tracking and a saturating stall-cycle counter.
module pipeline_hazard_controller #(
    parameter int MUL_LATENCY = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [4:0]  ID_RSField,
    input  logic [4:0]  ID_RTField,
    input  logic        ID_UsesRS,
    input  logic        ID_UsesRT,
    input  logic        ID_HiLoOp,
    input  logic        IDEX_MemRead,
    input  logic [4:0]  IDEX_DestReg,
    input  logic        IDEX_HiLoStart,
    input  logic        MEM_PCSrc,
    output logic        PCWrite,
    output logic        IFIDWrite,
    output logic        IDEXBubble,
    output logic        IFIDFlush,
    output logic        IDEXFlush,
    output logic        EXMEMFlush,
    output logic [1:0]  State,
    output logic [3:0]  BusyCount,
    output logic [15:0] StallCycles
);

    typedef enum logic [1:0] {
        RUN        = 2'b00,
        LOAD_STALL = 2'b01,
        HILO_WAIT  = 2'b10
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  busy_q, busy_d;
    logic [15:0] stall_q, stall_d;

    logic load_use;
    logic hilo_conflict;

    // The cycle after a load-use stall always lets the same producer/consumer pair through.
    assign load_use = IDEX_MemRead && (IDEX_DestReg != 5'd0) && (state_q != LOAD_STALL) &&
                      ((ID_UsesRS && (ID_RSField == IDEX_DestReg)) ||
                       (ID_UsesRT && (ID_RTField == IDEX_DestReg)));

    assign hilo_conflict = ID_HiLoOp && ((busy_q != 4'd0) || IDEX_HiLoStart);

    always_comb begin
        // NOTE: every output and next-state gets a default first so no path infers a latch.
        PCWrite    = 1'b1;
        IFIDWrite  = 1'b1;
        IDEXBubble = 1'b0;
        IFIDFlush  = 1'b0;
        IDEXFlush  = 1'b0;
        EXMEMFlush = 1'b0;
        state_d    = RUN;

        if (Reset || MEM_PCSrc) begin
            IFIDFlush  = 1'b1;
            IDEXFlush  = 1'b1;
            EXMEMFlush = 1'b1;
        end else if (load_use || hilo_conflict) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IDEXBubble = 1'b1;
            state_d    = load_use ? LOAD_STALL : HILO_WAIT;
        end
    end

    always_comb begin
        busy_d = busy_q;
        if (IDEX_HiLoStart && !MEM_PCSrc) begin
            busy_d = 4'(MUL_LATENCY - 1);
        end else if (busy_q != 4'd0) begin
            busy_d = busy_q - 4'd1;
        end

        stall_d = stall_q;
        if (!PCWrite && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge Clk) begin
        // NOTE: sequential state is assigned with non-blocking <= so all registers update together.
        if (Reset) begin
            state_q <= RUN;
            busy_q  <= 4'd0;
            stall_q <= 16'd0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            stall_q <= stall_d;
        end
    end

    assign State       = state_q;
    assign BusyCount   = busy_q;
    assign StallCycles = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench: a cycle-indexed model of the hazard rules checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_pipeline_hazard_controller;

    localparam int L = 4;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [4:0]  ID_RSField, ID_RTField, IDEX_DestReg;
    logic        ID_UsesRS, ID_UsesRT, ID_HiLoOp, IDEX_MemRead, IDEX_HiLoStart, MEM_PCSrc;
    logic        PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, IDEXFlush, EXMEMFlush;
    logic [1:0]  State;
    logic [3:0]  BusyCount;
    logic [15:0] StallCycles;

    int total = 0;
    int bad   = 0;

    pipeline_hazard_controller #(.MUL_LATENCY(L)) dut (
        .Clk(Clk), .Reset(Reset),
        .ID_RSField(ID_RSField), .ID_RTField(ID_RTField),
        .ID_UsesRS(ID_UsesRS), .ID_UsesRT(ID_UsesRT), .ID_HiLoOp(ID_HiLoOp),
        .IDEX_MemRead(IDEX_MemRead), .IDEX_DestReg(IDEX_DestReg),
        .IDEX_HiLoStart(IDEX_HiLoStart), .MEM_PCSrc(MEM_PCSrc),
        .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IDEXBubble(IDEXBubble),
        .IFIDFlush(IFIDFlush), .IDEXFlush(IDEXFlush), .EXMEMFlush(EXMEMFlush),
        .State(State), .BusyCount(BusyCount), .StallCycles(StallCycles)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the unit started at cycle last_start is busy for the L cycles after it,
    // reported as the cycles remaining; the stall reason is whatever stalled last cycle.
    int  cyc        = 0;
    int  last_start = 0;
    bit  started    = 1'b0;
    int  reason     = 0;
    int  stalls     = 0;
    bit  armed      = 1'b0;

    always @(negedge Clk) begin
        int  m_busy;
        bit  m_lu, m_hl, m_stall;
        m_busy = (started && (last_start + L > cyc)) ? (last_start + L - cyc) : 0;
        m_lu = IDEX_MemRead && (IDEX_DestReg != 0) && (reason != 1) &&
               ((ID_UsesRS && ID_RSField == IDEX_DestReg) ||
                (ID_UsesRT && ID_RTField == IDEX_DestReg));
        m_hl = ID_HiLoOp && (m_busy != 0 || IDEX_HiLoStart);
        m_stall = !Reset && !MEM_PCSrc && (m_lu || m_hl);

        if (armed) begin
            check("m_state", int'(State), reason);
            check("m_busy", int'(BusyCount), m_busy);
            check("m_stalls", int'(StallCycles), stalls);
            check("m_pcwrite", int'(PCWrite), int'(!m_stall));
            check("m_ifidwrite", int'(IFIDWrite), int'(!m_stall));
            check("m_bubble", int'(IDEXBubble), int'(m_stall));
            check("m_ifidflush", int'(IFIDFlush), int'(Reset || MEM_PCSrc));
            check("m_idexflush", int'(IDEXFlush), int'(Reset || MEM_PCSrc));
            check("m_exmemflush", int'(EXMEMFlush), int'(Reset || MEM_PCSrc));
        end

        if (Reset) begin
            reason  = 0;
            started = 1'b0;
            stalls  = 0;
            armed   = 1'b1;
        end else begin
            reason = MEM_PCSrc ? 0 : m_lu ? 1 : m_hl ? 2 : 0;
            if (IDEX_HiLoStart && !MEM_PCSrc) begin
                last_start = cyc;
                started    = 1'b1;
            end
            if (m_stall && stalls < 65535) stalls++;
        end
        cyc++;
    end

    task automatic next_cycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_inputs();
        ID_RSField = 0; ID_RTField = 0; IDEX_DestReg = 0;
        ID_UsesRS = 0; ID_UsesRT = 0; ID_HiLoOp = 0;
        IDEX_MemRead = 0; IDEX_HiLoStart = 0; MEM_PCSrc = 0;
    endtask

    initial begin
        clear_inputs();
        Reset = 1'b1;
        IDEX_HiLoStart = 1'b1;

        // Reset with a start op present
        @(negedge Clk);
        check("rst_flush", int'({IFIDFlush, IDEXFlush, EXMEMFlush}), 7);
        check("rst_pcwrite", int'(PCWrite), 1);
        next_cycle();
        next_cycle();
        Reset = 1'b0;
        IDEX_HiLoStart = 1'b0;
        @(negedge Clk);
        check("rst_busy", int'(BusyCount), 0);
        check("rst_state", int'(State), 0);
        check("rst_stalls", int'(StallCycles), 0);

        // Load-use on rt: one stall, then masked
        next_cycle();
        IDEX_MemRead = 1; IDEX_DestReg = 8; ID_UsesRT = 1; ID_RTField = 8;
        @(negedge Clk);
        check("lu_pcwrite0", int'(PCWrite), 0);
        check("lu_bubble0", int'(IDEXBubble), 1);
        next_cycle();
        @(negedge Clk);
        check("lu_state1", int'(State), 1);
        check("lu_pcwrite1", int'(PCWrite), 1);
        check("lu_stalls", int'(StallCycles), 1);
        next_cycle();
        IDEX_DestReg = 0; ID_RTField = 0;
        @(negedge Clk);
        check("lu_r0_pcwrite", int'(PCWrite), 1);
        next_cycle();
        clear_inputs();
        IDEX_MemRead = 1; IDEX_DestReg = 5; ID_UsesRS = 1; ID_RSField = 5;
        @(negedge Clk);
        check("lu_rs_pcwrite", int'(PCWrite), 0);
        next_cycle();
        clear_inputs();

        // HI/LO consumer directly behind a start op
        next_cycle();
        IDEX_HiLoStart = 1; ID_HiLoOp = 1;
        @(negedge Clk);
        check("hl_pcwrite_t", int'(PCWrite), 0);
        next_cycle();
        IDEX_HiLoStart = 0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge Clk);
            check("hl_pcwrite_k", int'(PCWrite), 0);
            check("hl_busy_k", int'(BusyCount), 4 - k);
            check("hl_state_k", int'(State), 2);
            next_cycle();
        end
        @(negedge Clk);
        check("hl_pcwrite_t4", int'(PCWrite), 1);
        check("hl_busy_t4", int'(BusyCount), 0);
        check("hl_state_t4", int'(State), 2);
        check("hl_stalls", int'(StallCycles), 6);
        next_cycle();
        clear_inputs();

        // Branch beats a live load-use
        IDEX_MemRead = 1; IDEX_DestReg = 8; ID_UsesRT = 1; ID_RTField = 8; MEM_PCSrc = 1;
        @(negedge Clk);
        check("br_flush", int'({IFIDFlush, IDEXFlush, EXMEMFlush}), 7);
        check("br_pcwrite", int'(PCWrite), 1);
        check("br_bubble", int'(IDEXBubble), 0);
        next_cycle();
        clear_inputs();
        MEM_PCSrc = 1;
        @(negedge Clk);
        check("br_state", int'(State), 0);
        check("br_b2b_flush", int'(EXMEMFlush), 1);
        next_cycle();
        MEM_PCSrc = 0;
        @(negedge Clk);
        check("br_end_flush", int'(IFIDFlush), 0);

        // Squashed start does not occupy the unit
        next_cycle();
        MEM_PCSrc = 1; IDEX_HiLoStart = 1;
        next_cycle();
        clear_inputs();
        ID_HiLoOp = 1;
        @(negedge Clk);
        check("sq_busy", int'(BusyCount), 0);
        check("sq_pcwrite", int'(PCWrite), 1);
        next_cycle();
        clear_inputs();

        // Reset in the middle of a HI/LO wait
        IDEX_HiLoStart = 1; ID_HiLoOp = 1;
        next_cycle();
        IDEX_HiLoStart = 0;
        @(negedge Clk);
        check("mid_busy", int'(BusyCount), 3);
        next_cycle();
        Reset = 1;
        @(negedge Clk);
        check("mid_rst_pcwrite", int'(PCWrite), 1);
        next_cycle();
        Reset = 0;
        ID_HiLoOp = 0;
        @(negedge Clk);
        check("mid_rst_busy", int'(BusyCount), 0);
        check("mid_rst_state", int'(State), 0);
        check("mid_rst_stalls", int'(StallCycles), 0);

        // Saturation: a stall every cycle for 70000 cycles
        next_cycle();
        IDEX_HiLoStart = 1; ID_HiLoOp = 1;
        repeat (70000) next_cycle();
        @(negedge Clk);
        check("sat_value", int'(StallCycles), 65535);
        repeat (3) next_cycle();
        @(negedge Clk);
        check("sat_hold", int'(StallCycles), 65535);
        next_cycle();
        clear_inputs();
        repeat (6) next_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_controller.md
# pipeline_hazard_controller

Stall and flush sequencer for the five-stage MIPS pipeline. It sits beside the IF/ID, ID/EX and EX/MEM pipeline registers. It detects load-use hazards, HI/LO multicycle-unit conflicts and taken branches resolved in MEM, and drives the PC-write, pipe-register hold, bubble and flush controls. It also keeps a saturating stall-cycle counter for performance checks.

## Interface
- MUL_LATENCY, 4: cycles the HI/LO multiply/accumulate unit stays busy after an op leaves EX; legal range 1..15.
- Clk  in  1  pipeline clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high.
- ID_RSField  in  5  rs of the instruction in ID.
- ID_RTField  in  5  rt of the instruction in ID.
- ID_UsesRS, ID_UsesRT  in  1 each  the instruction in ID reads rs / rt.
- ID_HiLoOp  in  1  the instruction in ID reads or writes HI/LO.
- IDEX_MemRead  in  1  the instruction in EX is a load.
- IDEX_DestReg  in  5  destination register of the instruction in EX.
- IDEX_HiLoStart  in  1  the instruction in EX starts a multicycle HI/LO op.
- MEM_PCSrc  in  1  taken branch resolved in MEM this cycle.
- PCWrite  out  1  PC update enable.
- IFIDWrite  out  1  IF/ID load enable.
- IDEXBubble  out  1  load zeroed controls into ID/EX.
- IFIDFlush, IDEXFlush, EXMEMFlush  out  1 each  clear that pipe register.
- State  out  2  00 RUN, 01 LOAD_STALL, 10 HILO_WAIT; 11 is never produced.
- BusyCount  out  4  remaining HI/LO busy cycles.
- StallCycles  out  16  count of cycles with PCWrite=0; saturates at 0xFFFF.

## Operation
- Terms:
  - LU (load-use) = IDEX_MemRead & IDEX_DestReg≠0 & ((ID_UsesRS & ID_RSField==IDEX_DestReg) | (ID_UsesRT & ID_RTField==IDEX_DestReg)).
  - LU is masked to 0 while State==LOAD_STALL.
  - HL (HI/LO conflict) = ID_HiLoOp & (BusyCount≠0 | IDEX_HiLoStart).
- Priority is MEM_PCSrc > LU > HL.
- Taken branch (MEM_PCSrc=1):
  - IFIDFlush=IDEXFlush=EXMEMFlush=1; PCWrite=1; IFIDWrite=1; IDEXBubble=0.
  - Any LU or HL stall in the same cycle is dropped; next State=RUN.
- Stall (LU or HL, no branch):
  - PCWrite=0, IFIDWrite=0, IDEXBubble=1; all flushes 0.
  - Next State=LOAD_STALL for LU, HILO_WAIT for HL.
- Otherwise: PCWrite=IFIDWrite=1, IDEXBubble=0, flushes 0, next State=RUN.
- State therefore reports the stall reason of the previous cycle.
- BusyCount:
  - Loads MUL_LATENCY-1 on IDEX_HiLoStart & !MEM_PCSrc. An op squashed by a same-cycle branch does not occupy the unit.
  - Otherwise decrements toward 0 and holds at 0.
  - A new start while busy reloads the count.
- StallCycles increments at each edge where PCWrite=0, unless already 0xFFFF.
- Reset=1 (sampled at edge):
  - State←RUN, BusyCount←0, StallCycles←0.
  - While Reset is high, combinationally: PCWrite=1, IFIDWrite=1, IDEXBubble=0, all three flushes=1.
  - Reset mid-stall discards the stall reason and the busy count.

## Timing
- Control outputs are combinational from current inputs plus registered State/BusyCount. They take effect in the same cycle; zero latency.
- State, BusyCount and StallCycles are registered; they change one edge after the cause.
- Load-use costs exactly 1 stall cycle. The following cycle is always non-stalling for the same producer because of LU masking.
- HI/LO consumer directly behind a start op (start in EX at cycle t, consumer in ID at t):
  - Stalled cycles t..t+MUL_LATENCY-1, i.e. MUL_LATENCY cycles.
  - Proceeds at t+MUL_LATENCY with BusyCount=0.
- Flushes last one cycle per MEM_PCSrc pulse. Back-to-back pulses flush on each cycle.

## Test plan
- Reset: Reset=1 for 2 cycles with IDEX_HiLoStart=1 → BusyCount=0, State=00, StallCycles=0, all flushes=1, PCWrite=1.
- Load-use: IDEX_MemRead=1, IDEX_DestReg=8, ID_UsesRT=1, ID_RTField=8 → cycle0 PCWrite=0, IDEXBubble=1. Cycle1 State=01, PCWrite=1. StallCycles=1. Repeat with DestReg=0 → no stall.
- HI/LO: IDEX_HiLoStart=1 and ID_HiLoOp=1 held at t → PCWrite=0 for t..t+3 with BusyCount 3,2,1 over t+1..t+3. PCWrite=1 at t+4, State=10 at t+1..t+4. StallCycles=4.
- Branch priority: MEM_PCSrc=1 together with an active LU → all flushes=1, PCWrite=1, IDEXBubble=0, next State=00.
- Squash: MEM_PCSrc=1 and IDEX_HiLoStart=1 in the same cycle → BusyCount stays 0. A following ID_HiLoOp does not stall.
- Saturation: force 70000 stall cycles → StallCycles=0xFFFF and holds.
